// File: rtl/ifw_pad_cnt_fsm.sv
// Write-side packing FSM for the ifmap buffer: walks left pad, data and right pad column
// segments per row, driving the SRAM write strobe, address and zero-insert flag.
module ifw_pad_cnt_fsm #(
  parameter int unsigned CNT00_WIDTH   = 10,
  parameter int unsigned CNT01_WIDTH   = 10,
  parameter int unsigned ROW_WIDTH     = 10,
  parameter int unsigned WS_ADDR_WIDTH = 10,
  parameter int unsigned PAD_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               cfg_mode,
  input  logic [PAD_WIDTH-1:0]     cfg_pad_left,
  input  logic [PAD_WIDTH-1:0]     cfg_pad_right,
  input  logic [CNT00_WIDTH-1:0]   cfg_cnt00_final,
  input  logic [CNT01_WIDTH-1:0]   cfg_cnt01_final,
  input  logic [ROW_WIDTH-1:0]     cfg_row_final,
  input  logic [WS_ADDR_WIDTH-1:0] cfg_srad_start,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     wr_en,
  output logic                     wr_pad,
  output logic [WS_ADDR_WIDTH-1:0] wr_addr,
  output logic [2:0]               dout_wr_curr_state,
  output logic [CNT00_WIDTH-1:0]   dout_wr_cnt00,
  output logic [CNT01_WIDTH-1:0]   dout_wr_cnt01,
  output logic [ROW_WIDTH-1:0]     dout_wr_row,
  output logic                     done
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLeft   = 3'd1,
    StNormal = 3'd2,
    StRigh   = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam logic [1:0] ModeBoth = 2'd0;
  localparam logic [1:0] ModeLeft = 2'd2;
  localparam logic [1:0] ModeRigh = 2'd3;

  state_e                   state_q, state_d;
  logic [CNT00_WIDTH-1:0]   cnt00_q, cnt00_d;
  logic [CNT01_WIDTH-1:0]   cnt01_q, cnt01_d;
  logic [ROW_WIDTH-1:0]     row_q, row_d;
  logic [WS_ADDR_WIDTH-1:0] addr_q, addr_d;

  // Latched tile configuration; pad counts are stored already masked by mode.
  logic [PAD_WIDTH-1:0]     pad_l_q, pad_l_d;
  logic [PAD_WIDTH-1:0]     pad_r_q, pad_r_d;
  logic [CNT00_WIDTH-1:0]   cnt00_final_q, cnt00_final_d;
  logic [CNT01_WIDTH-1:0]   cnt01_final_q, cnt01_final_d;
  logic [ROW_WIDTH-1:0]     row_final_q, row_final_d;

  logic [PAD_WIDTH-1:0]     cfg_pad_l_eff, cfg_pad_r_eff;
  logic [CNT01_WIDTH-1:0]   seg_final;
  logic                     seg_end;
  logic                     row_last;
  state_e                   row_first_state;

  always_comb begin
    cfg_pad_l_eff = ((cfg_mode == ModeBoth) || (cfg_mode == ModeLeft)) ? cfg_pad_left : '0;
    cfg_pad_r_eff = ((cfg_mode == ModeBoth) || (cfg_mode == ModeRigh)) ? cfg_pad_right : '0;
  end

  always_comb begin
    state_d       = state_q;
    cnt00_d       = cnt00_q;
    cnt01_d       = cnt01_q;
    row_d         = row_q;
    addr_d        = addr_q;
    pad_l_d       = pad_l_q;
    pad_r_d       = pad_r_q;
    cnt00_final_d = cnt00_final_q;
    cnt01_final_d = cnt01_final_q;
    row_final_d   = row_final_q;
    wr_en         = 1'b0;
    wr_pad        = 1'b0;
    din_ready     = 1'b0;
    done          = 1'b0;
    seg_final     = '0;

    row_last        = (row_q == row_final_q);
    row_first_state = (pad_l_q != '0) ? StLeft : StNormal;

    case (state_q)
      StIdle: begin
        if (start) begin
          pad_l_d       = cfg_pad_l_eff;
          pad_r_d       = cfg_pad_r_eff;
          cnt00_final_d = cfg_cnt00_final;
          cnt01_final_d = cfg_cnt01_final;
          row_final_d   = cfg_row_final;
          addr_d        = cfg_srad_start;
          cnt00_d       = '0;
          cnt01_d       = '0;
          row_d         = '0;
          state_d       = (cfg_pad_l_eff != '0) ? StLeft : StNormal;
        end
      end
      StLeft: begin
        wr_en     = 1'b1;
        wr_pad    = 1'b1;
        seg_final = CNT01_WIDTH'(pad_l_q) - CNT01_WIDTH'(1);
      end
      StNormal: begin
        din_ready = 1'b1;
        wr_en     = din_valid;
        seg_final = cnt01_final_q;
      end
      StRigh: begin
        wr_en     = 1'b1;
        wr_pad    = 1'b1;
        seg_final = CNT01_WIDTH'(pad_r_q) - CNT01_WIDTH'(1);
      end
      StDone: begin
        done    = 1'b1;
        cnt00_d = '0;
        cnt01_d = '0;
        row_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    seg_end = (cnt00_q == cnt00_final_q) && (cnt01_q == seg_final);

    // Counters and address only move on an actual write; a data stall freezes everything.
    if (wr_en) begin
      addr_d = addr_q + WS_ADDR_WIDTH'(1);
      if (seg_end) begin
        cnt00_d = '0;
        cnt01_d = '0;
        case (state_q)
          StLeft: state_d = StNormal;
          StNormal: begin
            if (pad_r_q != '0) begin
              state_d = StRigh;
            end else if (row_last) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + ROW_WIDTH'(1);
              state_d = row_first_state;
            end
          end
          StRigh: begin
            if (row_last) begin
              state_d = StDone;
            end else begin
              row_d   = row_q + ROW_WIDTH'(1);
              state_d = row_first_state;
            end
          end
          default: ;
        endcase
      end else if (cnt00_q == cnt00_final_q) begin
        cnt00_d = '0;
        cnt01_d = cnt01_q + CNT01_WIDTH'(1);
      end else begin
        cnt00_d = cnt00_q + CNT00_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt00_q       <= '0;
      cnt01_q       <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      pad_l_q       <= '0;
      pad_r_q       <= '0;
      cnt00_final_q <= '0;
      cnt01_final_q <= '0;
      row_final_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt00_q       <= cnt00_d;
      cnt01_q       <= cnt01_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      pad_l_q       <= pad_l_d;
      pad_r_q       <= pad_r_d;
      cnt00_final_q <= cnt00_final_d;
      cnt01_final_q <= cnt01_final_d;
      row_final_q   <= row_final_d;
    end
  end

  assign wr_addr            = addr_q;
  assign dout_wr_curr_state = state_q;
  assign dout_wr_cnt00      = cnt00_q;
  assign dout_wr_cnt01      = cnt01_q;
  assign dout_wr_row        = row_q;

endmodule

// File: tb/tb_ifw_pad_cnt_fsm.sv
// Bench for ifw_pad_cnt_fsm: table-driven tiles and random tiles against a write-list model,
// plus hand sequences for stalls, ignored restart and mid-tile reset.
module tb_ifw_pad_cnt_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [2:0]  cfg_pad_left, cfg_pad_right;
  logic [9:0]  cfg_cnt00_final, cfg_cnt01_final, cfg_row_final, cfg_srad_start;
  logic        din_valid;
  logic        din_ready, wr_en, wr_pad, done;
  logic [9:0]  wr_addr, dout_wr_cnt00, dout_wr_cnt01, dout_wr_row;
  logic [2:0]  dout_wr_curr_state;

  always #5 clk = ~clk;

  ifw_pad_cnt_fsm dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .cfg_mode           (cfg_mode),
    .cfg_pad_left       (cfg_pad_left),
    .cfg_pad_right      (cfg_pad_right),
    .cfg_cnt00_final    (cfg_cnt00_final),
    .cfg_cnt01_final    (cfg_cnt01_final),
    .cfg_row_final      (cfg_row_final),
    .cfg_srad_start     (cfg_srad_start),
    .din_valid          (din_valid),
    .din_ready          (din_ready),
    .wr_en              (wr_en),
    .wr_pad             (wr_pad),
    .wr_addr            (wr_addr),
    .dout_wr_curr_state (dout_wr_curr_state),
    .dout_wr_cnt00      (dout_wr_cnt00),
    .dout_wr_cnt01      (dout_wr_cnt01),
    .dout_wr_row        (dout_wr_row),
    .done               (done)
  );

  typedef struct {
    int addr; int pad; int st; int c00; int c01; int row;
  } wr_t;

  typedef struct {
    int mode; int pl; int pr; int c00f; int c01f; int rowf; int srad; int vpct;
    int exp_writes; int exp_pads; int exp_last;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vecs[6];
  int stall_v[6]  = '{1, 0, 0, 1, 1, 1};
  int stall_en[6] = '{1, 0, 0, 1, 1, 1};
  int stall_a[6]  = '{0, 1, 1, 1, 2, 3};
  int stall_c0[6] = '{0, 1, 1, 1, 0, 1};
  int stall_c1[6] = '{0, 0, 0, 0, 1, 1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " state"}, int'(dout_wr_curr_state), 0);
    chk({tag, " wr_en"}, int'(wr_en), 0);
    chk({tag, " din_ready"}, int'(din_ready), 0);
    chk({tag, " wr_pad"}, int'(wr_pad), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " wr_addr"}, int'(wr_addr), 0);
    chk({tag, " cnt00"}, int'(dout_wr_cnt00), 0);
    chk({tag, " cnt01"}, int'(dout_wr_cnt01), 0);
    chk({tag, " row"}, int'(dout_wr_row), 0);
  endtask

  task automatic apply_start(input int mode, input int pl, input int pr, input int c00f,
                             input int c01f, input int rowf, input int srad);
    @(negedge clk);
    cfg_mode        = 2'(mode);
    cfg_pad_left    = 3'(pl);
    cfg_pad_right   = 3'(pr);
    cfg_cnt00_final = 10'(c00f);
    cfg_cnt01_final = 10'(c01f);
    cfg_row_final   = 10'(rowf);
    cfg_srad_start  = 10'(srad);
    din_valid       = 1'b0;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one tile; expected writes are enumerated row by row, segment by segment.
  task automatic run_tile(input int mode, input int pl, input int pr, input int c00f,
                          input int c01f, input int rowf, input int srad, input int vpct,
                          output int nwr, output int npad, output int last);
    wr_t q[$];
    wr_t w;
    int pad_l, pad_r, words, n, cyc, budget, exp_en;
    int seg_cols[3];
    pad_l = (mode == 0 || mode == 2) ? pl : 0;
    pad_r = (mode == 0 || mode == 3) ? pr : 0;
    seg_cols[0] = pad_l;
    seg_cols[1] = c01f + 1;
    seg_cols[2] = pad_r;
    words = c00f + 1;
    n = 0;
    for (int r = 0; r <= rowf; r++) begin
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < seg_cols[s] * words; k++) begin
          w.addr = (srad + n) % 1024;
          w.pad  = (s != 1) ? 1 : 0;
          w.st   = s + 1;
          w.c00  = k % words;
          w.c01  = k / words;
          w.row  = r;
          q.push_back(w);
          n++;
        end
      end
    end
    nwr = 0; npad = 0; last = -1;
    apply_start(mode, pl, pr, c00f, c01f, rowf, srad);
    // Scramble config after the start cycle; it must already be latched.
    cfg_mode        = 2'($urandom_range(3));
    cfg_pad_left    = 3'($urandom_range(7));
    cfg_pad_right   = 3'($urandom_range(7));
    cfg_cnt00_final = 10'($urandom_range(7));
    cfg_cnt01_final = 10'($urandom_range(7));
    cfg_row_final   = 10'($urandom_range(7));
    cfg_srad_start  = 10'($urandom_range(1023));
    budget = 30 * q.size() + 100;
    cyc = 0;
    while (q.size() > 0 && cyc < budget) begin
      din_valid = ($urandom_range(99) < vpct);
      #1;
      exp_en = (q[0].st != 2 || din_valid) ? 1 : 0;
      chk("wr_en", int'(wr_en), exp_en);
      chk("state", int'(dout_wr_curr_state), q[0].st);
      chk("din_ready", int'(din_ready), (q[0].st == 2) ? 1 : 0);
      chk("wr_addr", int'(wr_addr), q[0].addr);
      chk("cnt00", int'(dout_wr_cnt00), q[0].c00);
      chk("cnt01", int'(dout_wr_cnt01), q[0].c01);
      chk("row", int'(dout_wr_row), q[0].row);
      chk("done in tile", int'(done), 0);
      if (exp_en == 1) begin
        chk("wr_pad", int'(wr_pad), q[0].pad);
        if (wr_en) begin
          nwr++;
          npad += int'(wr_pad);
          last = int'(wr_addr);
        end
        void'(q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    if (q.size() > 0) chk("tile cycle budget", q.size(), 0);
    din_valid = 1'b0;
    #1;
    chk("done pulse", int'(done), 1);
    chk("done state", int'(dout_wr_curr_state), 4);
    chk("done wr_en", int'(wr_en), 0);
    chk("done cnt00", int'(dout_wr_cnt00), 0);
    chk("done cnt01", int'(dout_wr_cnt01), 0);
    @(negedge clk);
    #1;
    chk("post done", int'(done), 0);
    chk("post state", int'(dout_wr_curr_state), 0);
    chk("post row", int'(dout_wr_row), 0);
    chk("post addr hold", int'(wr_addr), (srad + n) % 1024);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int nwr, npad, last, mode, pl, pr, c00f, c01f, rowf, srad;
    vecs[0] = '{1, 0, 0, 1, 2, 1, 5,    100, 12, 0,  16};
    vecs[1] = '{0, 1, 2, 0, 1, 0, 0,    100, 5,  3,  4};
    vecs[2] = '{2, 0, 3, 1, 1, 1, 100,  60,  8,  0,  107};
    vecs[3] = '{1, 0, 0, 1, 1, 0, 1022, 100, 4,  0,  1};
    vecs[4] = '{3, 5, 2, 2, 0, 1, 10,   50,  18, 12, 27};
    vecs[5] = '{2, 3, 1, 0, 3, 2, 50,   70,  21, 9,  70};

    reset = 1'b1; start = 1'b0; din_valid = 1'b0;
    cfg_mode = '0; cfg_pad_left = '0; cfg_pad_right = '0; cfg_cnt00_final = '0;
    cfg_cnt01_final = '0; cfg_row_final = '0; cfg_srad_start = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_tile(vecs[i].mode, vecs[i].pl, vecs[i].pr, vecs[i].c00f, vecs[i].c01f,
               vecs[i].rowf, vecs[i].srad, vecs[i].vpct, nwr, npad, last);
      chk($sformatf("vec%0d writes", i), nwr, vecs[i].exp_writes);
      chk($sformatf("vec%0d pads", i), npad, vecs[i].exp_pads);
      chk($sformatf("vec%0d last addr", i), last, vecs[i].exp_last);
    end

    // Stall: din_valid 1,0,0,1 holds counters and address with din_ready still high.
    apply_start(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      din_valid = stall_v[i][0];
      #1;
      chk($sformatf("stall%0d wr_en", i), int'(wr_en), stall_en[i]);
      chk($sformatf("stall%0d din_ready", i), int'(din_ready), 1);
      chk($sformatf("stall%0d addr", i), int'(wr_addr), stall_a[i]);
      chk($sformatf("stall%0d cnt00", i), int'(dout_wr_cnt00), stall_c0[i]);
      chk($sformatf("stall%0d cnt01", i), int'(dout_wr_cnt01), stall_c1[i]);
      @(negedge clk);
    end
    din_valid = 1'b0;
    #1;
    chk("stall done", int'(done), 1);
    @(negedge clk);
    #1;
    chk("stall idle", int'(dout_wr_curr_state), 0);
    chk("stall addr hold", int'(wr_addr), 4);

    // Restart mid-tile is ignored; reset at the third write aborts without a done pulse.
    apply_start(1, 0, 0, 1, 2, 1, 5);
    din_valid = 1'b1;
    #1;
    chk("ign w1 addr", int'(wr_addr), 5);
    start = 1'b1; cfg_srad_start = 10'd200; cfg_mode = 2'd0; cfg_pad_left = 3'd3;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("ign w2 addr", int'(wr_addr), 6);
    chk("ign w2 state", int'(dout_wr_curr_state), 2);
    chk("ign w2 pad", int'(wr_pad), 0);
    @(negedge clk);
    #1;
    chk("ign w3 addr", int'(wr_addr), 7);
    chk("ign w3 cnt01", int'(dout_wr_cnt01), 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_idle_zero("midreset");
    reset = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset no done", int'(done), 0);
    chk("midreset idle", int'(dout_wr_curr_state), 0);
    run_tile(1, 0, 0, 1, 2, 1, 5, 100, nwr, npad, last);
    chk("rerun writes", nwr, 12);
    chk("rerun last addr", last, 16);

    for (int t = 0; t < 25; t++) begin
      mode = $urandom_range(3); pl = $urandom_range(3); pr = $urandom_range(3);
      c00f = $urandom_range(2); c01f = $urandom_range(3); rowf = $urandom_range(2);
      srad = $urandom_range(1023);
      run_tile(mode, pl, pr, c00f, c01f, rowf, srad, 60, nwr, npad, last);
      chk($sformatf("rand%0d writes", t), nwr,
          (rowf + 1) * (c00f + 1) * (((mode == 0 || mode == 2) ? pl : 0) + c01f + 1 +
          ((mode == 0 || mode == 3) ? pr : 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
